// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner.
// Segment patterns are active-low; bit 7 is the decimal point.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] DP_MASK   = 8'h7F;

  // entry n sits at [n*8 +: 8], digit F first
  localparam logic [127:0] HEX7_TAB = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,
    8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99,
    8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg_scan_display_hex7seg.sv
// Hex nibble to active-low g..a segment decoder.
// Purely combinational lookup into the package table.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg7
);

  assign seg7 = HEX7_TAB[{nib, 3'b000} +: 7];

endmodule

// File: rtl/seg_scan_display.sv
// Multi-channel hex scanner with frame-aligned snapshots,
// freeze hold and leading-zero blanking.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000,
  parameter int SEL_W    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*DIGITS*4-1:0] ch_data,
  input  logic [SEL_W-1:0]           ch_sel,
  input  logic                       freeze,
  input  logic                       lz_blank,
  output logic [DIGITS-1:0]          an,
  output logic [7:0]                 seg,
  output logic [SEL_W-1:0]           cur_ch
);

  localparam int W  = DIGITS * 4;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]     presc;
  logic [DW-1:0]     dig;
  logic [W-1:0]      snap;
  logic [W-1:0]      word;
  logic              bad;
  logic              load_pend;
  logic              tick;
  logic              last;
  logic              frame_end;
  logic              load;
  logic              sel_ok;
  logic              zrun;
  logic [DIGITS-1:0] blank;
  logic [DIGITS-1:0] oh;
  logic [3:0]        nib;
  logic [6:0]        seg7;
  logic [DIGITS-1:0] an_d;
  logic [7:0]        seg_d;

  assign tick      = presc == PW'(SCAN_DIV - 1);
  assign last      = dig == DW'(DIGITS - 1);
  assign frame_end = tick && last;
  assign load      = (load_pend || frame_end) && !freeze;
  assign sel_ok    = 32'(ch_sel) < NUM_CH;
  assign nib       = snap[{dig, 2'b00} +: 4];
  assign oh        = DIGITS'(1) << dig;

  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (32'(ch_sel) == k)
        word = ch_data[k*W +: W];
  end

  // a digit blanks when it and every higher nibble is zero
  always_comb begin
    zrun  = 1'b1;
    blank = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zrun     = zrun & (snap[i*4 +: 4] == 4'h0);
      blank[i] = zrun & lz_blank & ~bad;
    end
  end

  hex7seg u_hex (
    .nib  (nib),
    .seg7 (seg7)
  );

  always_comb begin
    an_d  = ~oh;
    seg_d = {1'b1, seg7};
    if (bad) begin
      seg_d = (dig == '0) ? (SEG_DASH & DP_MASK) : SEG_DASH;
    end else if (blank[dig]) begin
      an_d  = '1;
      seg_d = SEG_BLANK;
    end else if (freeze && last) begin
      seg_d = seg_d & DP_MASK;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc     <= '0;
      dig       <= '0;
      snap      <= '0;
      cur_ch    <= '0;
      bad       <= 1'b0;
      load_pend <= 1'b1;
      an        <= '1;
      seg       <= SEG_BLANK;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        dig <= last ? '0 : dig + 1'b1;
        an  <= an_d;
        seg <= seg_d;
      end
      if (load) begin
        load_pend <= 1'b0;
        cur_ch    <= ch_sel;
        if (sel_ok) begin
          snap <= word;
          bad  <= 1'b0;
        end else begin
          bad  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display (SCAN_DIV=4, DIGITS=8).
// NUM_CH=6 so that ch_sel=7 is out of range.
module tb_seg_scan_display;

  logic         clk = 1'b0;
  logic         rst;
  logic [191:0] ch_data;
  logic [2:0]   ch_sel;
  logic         freeze;
  logic         lz_blank;
  logic [7:0]   an;
  logic [7:0]   seg;
  logic [2:0]   cur_ch;

  int total = 0;
  int bad   = 0;

  // 32'h1234ABCD and 32'h89ABCDEF, digit 0 first
  logic [7:0] e2 [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88,
                         8'h99, 8'hB0, 8'hA4, 8'hF9};
  logic [7:0] e5 [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6,
                         8'h83, 8'h88, 8'h90, 8'h80};

  seg_scan_display #(
    .NUM_CH   (6),
    .DIGITS   (8),
    .SCAN_DIV (4),
    .SEL_W    (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_data  (ch_data),
    .ch_sel   (ch_sel),
    .freeze   (freeze),
    .lz_blank (lz_blank),
    .an       (an),
    .seg      (seg),
    .cur_ch   (cur_ch)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ch(input int k, input logic [31:0] v);
    ch_data[k*32 +: 32] = v;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    ch_data = '0;
    ch_sel = 3'd2;
    freeze = 1'b0;
    lz_blank = 1'b0;
    set_ch(2, 32'h1234ABCD);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({an, seg, cur_ch} !== {8'hFF, 8'hFF, 3'd0}) begin
      bad++;
      $display("FAIL reset: an=%h seg=%h ch=%0d want FF FF 0",
               an, seg, cur_ch);
    end
    rst = 1'b1;
  endtask

  task automatic test_load;
    logic [7:0] ea;
    step(1);
    total++;
    if ({an, seg, cur_ch} !== {8'hFF, 8'hFF, 3'd2}) begin
      bad++;
      $display("FAIL load_idle: an=%h seg=%h ch=%0d want FF FF 2",
               an, seg, cur_ch);
    end
    step(3);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step(4);
      ea = ~(8'd1 << k);
      total++;
      if ({an, seg} !== {ea, e2[k]}) begin
        bad++;
        $display("FAIL load_d%0d: an=%h seg=%h want %h %h",
                 k, an, seg, ea, e2[k]);
      end
    end
  endtask

  task automatic test_no_tear;
    logic [7:0] ea;
    step(8);
    ch_sel = 3'd5;
    set_ch(5, 32'h89ABCDEF);
    for (int k = 2; k < 7; k++) begin
      step(4);
      ea = ~(8'd1 << k);
      total++;
      if ({an, seg, cur_ch} !== {ea, e2[k], 3'd2}) begin
        bad++;
        $display("FAIL tear_d%0d: an=%h seg=%h ch=%0d want %h %h 2",
                 k, an, seg, cur_ch, ea, e2[k]);
      end
    end
    step(3);
    total++;
    if (cur_ch !== 3'd2) begin
      bad++;
      $display("FAIL tear_early: ch=%0d want 2", cur_ch);
    end
    step(1);
    total++;
    if ({an, seg, cur_ch} !== {8'h7F, 8'hF9, 3'd5}) begin
      bad++;
      $display("FAIL tear_end: an=%h seg=%h ch=%0d want 7F F9 5",
               an, seg, cur_ch);
    end
    step(4);
    total++;
    if ({an, seg} !== {8'hFE, 8'h8E}) begin
      bad++;
      $display("FAIL tear_new: an=%h seg=%h want FE 8E", an, seg);
    end
  endtask

  task automatic test_freeze;
    logic [7:0] ea;
    logic [7:0] es;
    freeze = 1'b1;
    set_ch(5, 32'h11111111);
    for (int f = 0; f < 3; f++) begin
      for (int k = 1; k < 9; k++) begin
        step(4);
        ea = ~(8'd1 << (k % 8));
        es = e5[k % 8];
        if (k == 7) es = es & 8'h7F;
        total++;
        if ({an, seg} !== {ea, es}) begin
          bad++;
          $display("FAIL frz_f%0d_d%0d: an=%h seg=%h want %h %h",
                   f, k % 8, an, seg, ea, es);
        end
      end
    end
    freeze = 1'b0;
    for (int k = 1; k < 8; k++) begin
      step(4);
      ea = ~(8'd1 << k);
      total++;
      if ({an, seg} !== {ea, e5[k]}) begin
        bad++;
        $display("FAIL unfrz_d%0d: an=%h seg=%h want %h %h",
                 k, an, seg, ea, e5[k]);
      end
    end
    step(4);
    total++;
    if ({an, seg, cur_ch} !== {8'hFE, 8'hF9, 3'd5}) begin
      bad++;
      $display("FAIL unfrz_new: an=%h seg=%h ch=%0d want FE F9 5",
               an, seg, cur_ch);
    end
  endtask

  task automatic test_blank;
    logic [7:0] ea;
    logic [7:0] es;
    lz_blank = 1'b1;
    set_ch(5, 32'h000000A0);
    step(32);
    total++;
    if ({an, seg} !== {8'hFE, 8'hC0}) begin
      bad++;
      $display("FAIL blk_a0_d0: an=%h seg=%h want FE C0", an, seg);
    end
    set_ch(5, 32'h0);
    for (int k = 1; k < 8; k++) begin
      step(4);
      ea = (k == 1) ? 8'hFD : 8'hFF;
      es = (k == 1) ? 8'h88 : 8'hFF;
      total++;
      if ({an, seg} !== {ea, es}) begin
        bad++;
        $display("FAIL blk_a0_d%0d: an=%h seg=%h want %h %h",
                 k, an, seg, ea, es);
      end
    end
    step(4);
    total++;
    if ({an, seg} !== {8'hFE, 8'hC0}) begin
      bad++;
      $display("FAIL blk_0_d0: an=%h seg=%h want FE C0", an, seg);
    end
    for (int k = 1; k < 8; k++) begin
      step(4);
      total++;
      if ({an, seg} !== {8'hFF, 8'hFF}) begin
        bad++;
        $display("FAIL blk_0_d%0d: an=%h seg=%h want FF FF",
                 k, an, seg);
      end
    end
  endtask

  task automatic test_bad_sel;
    logic [7:0] ea;
    lz_blank = 1'b0;
    ch_sel = 3'd7;
    step(32);
    total++;
    if ({an, seg} !== {8'h7F, 8'hC0}) begin
      bad++;
      $display("FAIL bad_pre: an=%h seg=%h want 7F C0", an, seg);
    end
    step(4);
    total++;
    if ({an, seg, cur_ch} !== {8'hFE, 8'h3F, 3'd7}) begin
      bad++;
      $display("FAIL bad_d0: an=%h seg=%h ch=%0d want FE 3F 7",
               an, seg, cur_ch);
    end
    ch_sel = 3'd1;
    set_ch(1, 32'h00000042);
    for (int k = 1; k < 8; k++) begin
      step(4);
      ea = ~(8'd1 << k);
      total++;
      if ({an, seg} !== {ea, 8'hBF}) begin
        bad++;
        $display("FAIL bad_d%0d: an=%h seg=%h want %h BF",
                 k, an, seg, ea);
      end
    end
    step(4);
    total++;
    if ({an, seg, cur_ch} !== {8'hFE, 8'hA4, 3'd1}) begin
      bad++;
      $display("FAIL bad_fix: an=%h seg=%h ch=%0d want FE A4 1",
               an, seg, cur_ch);
    end
  endtask

  task automatic test_async_reset;
    step(12);
    total++;
    if ({an, seg} !== {8'hF7, 8'hC0}) begin
      bad++;
      $display("FAIL ar_pre: an=%h seg=%h want F7 C0", an, seg);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({an, seg, cur_ch} !== {8'hFF, 8'hFF, 3'd0}) begin
      bad++;
      $display("FAIL ar_now: an=%h seg=%h ch=%0d want FF FF 0",
               an, seg, cur_ch);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(1);
    total++;
    if ({an, seg, cur_ch} !== {8'hFF, 8'hFF, 3'd1}) begin
      bad++;
      $display("FAIL ar_idle: an=%h seg=%h ch=%0d want FF FF 1",
               an, seg, cur_ch);
    end
    step(3);
    total++;
    if ({an, seg} !== {8'hFE, 8'hA4}) begin
      bad++;
      $display("FAIL ar_d0: an=%h seg=%h want FE A4", an, seg);
    end
    step(4);
    total++;
    if ({an, seg} !== {8'hFD, 8'h99}) begin
      bad++;
      $display("FAIL ar_d1: an=%h seg=%h want FD 99", an, seg);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_no_tear();
    test_freeze();
    test_blank();
    test_bad_sel();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
